// File: rtl/ct_pkg.sv
// rtl/ct_pkg.sv - shared op codes, FSM states and per-bit shadow helper for the CT command driver
//
// Purpose : constants and types shared by ct_cmd_fifo and ct_cmd_driver.
//   OP_*      : {c,t} latch codes (00 toggle, 01 clear, 10 set, 11 hold)
//   ct_state_e: driver sequencer states (2-bit)
//   ct_next_bit: predicted latch output after one enable pulse with a given code

package ct_pkg;

  localparam logic [1:0] OP_TOGGLE = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_PULSE   = 2'd2,
    ST_RECOVER = 2'd3
  } ct_state_e;

  function automatic logic ct_next_bit(input logic [1:0] op, input logic q);
    logic r;
    case (op)
      OP_TOGGLE: r = ~q;
      OP_CLEAR:  r = 1'b0;
      OP_SET:    r = 1'b1;
      default:   r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ct_cmd_fifo.sv
// rtl/ct_cmd_fifo.sv - command FIFO holding {op,mask} entries for the CT driver
//
// Purpose : DEPTH-deep, DW-wide synchronous FIFO, first-word-fall-through read.
// Ports   :
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write wdata when not full (ignored when full)
//   pop        : drop head entry when not empty (ignored when empty)
//   wdata      : entry to write
//   rdata      : current head entry (valid when !empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two (pointers wrap by natural overflow).

module ct_cmd_fifo
  import ct_pkg::*;
#(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // Pop is evaluated against the pre-edge occupancy, so push+pop on a
  // non-full, non-empty FIFO keeps count unchanged.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ct_cmd_driver.sv
// rtl/ct_cmd_driver.sv - queues CT latch commands and plays each as setup / one enable pulse / recover
//
// Purpose : accepts {op,mask} commands over valid/ready, buffers them in ct_cmd_fifo and
//           drives a CT latch bank so the level-sensitive toggle code sees exactly one
//           enable pulse with stable codes around it. Keeps a shadow of the bank state.
// Ports   :
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready = FIFO not full)
//   cmd_op, cmd_mask    : {c,t} code and per-bit select (unselected bits get HOLD)
//   lat_clk             : latch enable, high for exactly one cycle per command
//   lat_c, lat_t        : per-bit codes to the bank (all HOLD when idle)
//   shadow_q            : predicted bank state after the last pulse
//   busy                : sequencer active or commands queued
//   q_fb                : bank feedback, used only by the optional checker
//   mismatch            : sticky shadow/feedback disagreement
// Configuration : define CT_SHADOW_CHECK_EN to build the known-bit register and the
//                 feedback checker; otherwise mismatch is 0 and q_fb is ignored.

module ct_cmd_driver
  import ct_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic             lat_clk,
  output logic [WIDTH-1:0] lat_c,
  output logic [WIDTH-1:0] lat_t,
  output logic [WIDTH-1:0] shadow_q,
  output logic             busy,
  input  logic [WIDTH-1:0] q_fb,
  output logic             mismatch
);

  ct_state_e               state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [WIDTH-1:0]        mask_q, mask_d;
  logic [WIDTH-1:0]        shadow_d;
  logic [WIDTH-1:0]        shadow_next;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [WIDTH+1:0]        fifo_rdata;
  logic [$clog2(DEPTH):0]  fifo_count_unused;

  ct_cmd_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .wdata ({cmd_op, cmd_mask}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign cmd_ready = ~fifo_full;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;

  // Outputs decode straight from the state register so an asynchronous
  // reset drops lat_clk and returns the codes to HOLD immediately.
  assign lat_clk = (state_q == ST_PULSE);
  assign lat_c   = (state_q == ST_IDLE) ? '1 : (~mask_q | {WIDTH{op_q[1]}});
  assign lat_t   = (state_q == ST_IDLE) ? '1 : (~mask_q | {WIDTH{op_q[0]}});

  always_comb begin
    shadow_next = shadow_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask_q[i]) shadow_next[i] = ct_next_bit(op_q, shadow_q[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE, ST_RECOVER: begin
        if (!fifo_empty) begin
          fifo_pop         = 1'b1;
          {op_d, mask_d}   = fifo_rdata;
          state_d          = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: state_d = ST_PULSE;
      ST_PULSE: begin
        // The bank captures on this pulse; the shadow follows on entry to RECOVER.
        shadow_d = shadow_next;
        state_d  = ST_RECOVER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_HOLD;
      mask_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef CT_SHADOW_CHECK_EN
  logic [WIDTH-1:0] known_q, known_d;
  logic             mismatch_q, mismatch_d;

  always_comb begin
    known_d    = known_q;
    mismatch_d = mismatch_q;
    // Only SET/CLEAR make a bit's value independent of power-up history.
    if (state_q == ST_PULSE && (op_q == OP_SET || op_q == OP_CLEAR)) begin
      known_d = known_q | mask_q;
    end
    // Compare only when codes are HOLD or settled after the pulse.
    if ((state_q == ST_IDLE || state_q == ST_RECOVER) &&
        |((q_fb ^ shadow_q) & known_q)) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      known_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      known_q    <= known_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_ct_cmd_driver.sv
// tb/tb_ct_cmd_driver.sv - self-checking bench for ct_cmd_driver against a command-queue model

module tb_ct_cmd_driver;
  import ct_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = OP_HOLD;
  logic [WIDTH-1:0] cmd_mask = '0;
  logic             lat_clk;
  logic [WIDTH-1:0] lat_c, lat_t, shadow_q;
  logic             busy;
  logic [WIDTH-1:0] q_fb = '0;
  logic             mismatch;

  ct_cmd_driver #(.WIDTH(WIDTH), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .lat_clk(lat_clk), .lat_c(lat_c),
    .lat_t(lat_t), .shadow_q(shadow_q), .busy(busy), .q_fb(q_fb), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  logic [9:0]       model_q[$];
  int               pulse_times[$];
  logic [WIDTH-1:0] m_shadow = '0;
  logic             exp_mismatch = 1'b0;
  logic             pend = 1'b0;
  logic [WIDTH-1:0] pend_c, pend_t;
  logic             prev_clk = 1'b0;
  logic             saw_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Model of one command applied to the bank: selected bits follow the op.
  function automatic logic [WIDTH-1:0] apply_cmd(input logic [WIDTH-1:0] s,
                                                 input logic [1:0] op,
                                                 input logic [WIDTH-1:0] m);
    case (op)
      OP_SET:    return s | m;
      OP_CLEAR:  return s & ~m;
      OP_TOGGLE: return s ^ m;
      default:   return s;
    endcase
  endfunction

  // Pulse monitor: every enable pulse must carry the oldest accepted command.
  always @(negedge clk) begin
    logic [9:0] cmd;
    ncyc++;
    if (!rst_n) begin
      pend     = 1'b0;
      prev_clk = 1'b0;
    end else begin
      if (!cmd_ready) saw_full = 1'b1;
      check("mismatch_flag", mismatch, exp_mismatch);
      if (pend) begin
        check("recover_shadow", shadow_q, m_shadow);
        check("recover_clk", lat_clk, 0);
        check("recover_c", lat_c, pend_c);
        check("recover_t", lat_t, pend_t);
        pend = 1'b0;
      end
      if (lat_clk) begin
        check("pulse_single", prev_clk, 0);
        check("pulse_expected", model_q.size() > 0, 1);
        if (model_q.size() > 0) begin
          cmd    = model_q.pop_front();
          pend_c = ~cmd[7:0] | {WIDTH{cmd[9]}};
          pend_t = ~cmd[7:0] | {WIDTH{cmd[8]}};
          check("pulse_c", lat_c, pend_c);
          check("pulse_t", lat_t, pend_t);
          m_shadow = apply_cmd(m_shadow, cmd[9:8], cmd[7:0]);
          q_fb     = m_shadow;
          pend     = 1'b1;
          pulse_times.push_back(ncyc);
        end
      end
      if (!busy) begin
        check("idle_c", lat_c, 8'hFF);
        check("idle_t", lat_t, 8'hFF);
        check("idle_clk", lat_clk, 0);
      end
      prev_clk = lat_clk;
    end
  end

  task automatic push_cmd(input logic [1:0] op, input logic [WIDTH-1:0] m);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = m;
    while (!cmd_ready && g < 100) begin
      tick();
      g++;
    end
    check("push_wait_bound", g < 100, 1);
    model_q.push_back({op, m});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((busy || model_q.size() != 0 || pend) && g < 300) begin
      tick();
      g++;
    end
    check(tag, g < 300, 1);
  endtask

  initial begin
    int accept_n;
    int g;

    // Reset state
    tick(); tick();
    check("rst_lat_c", lat_c, 8'hFF);
    check("rst_lat_t", lat_t, 8'hFF);
    check("rst_lat_clk", lat_clk, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_shadow", shadow_q, 8'h00);
    check("rst_mismatch", mismatch, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("quiet_ready", cmd_ready, 1);
      check("quiet_busy", busy, 0);
      check("quiet_lat_clk", lat_clk, 0);
    end

    // CLEAR FF then SET 0F, with first-command latency
    pulse_times.delete();
    push_cmd(OP_CLEAR, 8'hFF);
    accept_n = ncyc;
    check("lat_e0_busy", busy, 1);
    check("lat_e0_clk", lat_clk, 0);
    check("lat_e0_c", lat_c, 8'hFF);
    push_cmd(OP_SET, 8'h0F);
    check("lat_setup_c", lat_c, 8'h00);
    check("lat_setup_t", lat_t, 8'hFF);
    check("lat_setup_clk", lat_clk, 0);
    tick();
    check("lat_pulse_clk", lat_clk, 1);
    drain("drain_clear_set");
    check("clear_set_pulses", pulse_times.size(), 2);
    if (pulse_times.size() >= 2) begin
      check("first_pulse_time", pulse_times[0], accept_n + 2);
      check("pulse_spacing", pulse_times[1] - pulse_times[0], 3);
    end
    check("shadow_after_set", shadow_q, 8'h0F);

    // TOGGLE 3C from 0F
    push_cmd(OP_TOGGLE, 8'h3C);
    tick();
    check("tog_setup_c", lat_c, 8'hC3);
    check("tog_setup_t", lat_t, 8'hC3);
    check("tog_setup_clk", lat_clk, 0);
    tick();
    check("tog_pulse_clk", lat_clk, 1);
    check("tog_pulse_c", lat_c, 8'hC3);
    tick();
    check("tog_rec_c", lat_c, 8'hC3);
    check("tog_rec_t", lat_t, 8'hC3);
    check("tog_shadow", shadow_q, 8'h33);
    drain("drain_toggle");

    // Randomized commands with random gaps
    for (int i = 0; i < 24; i++) begin
      push_cmd(2'($urandom_range(0, 3)), 8'($urandom));
      for (int k = $urandom_range(0, 3); k > 0; k--) tick();
    end
    drain("drain_random");
    check("random_shadow", shadow_q, m_shadow);

    // Burst into a busy FSM: FIFO must fill and stall without losing commands
    pulse_times.delete();
    saw_full = 1'b0;
    push_cmd(OP_SET, 8'hF0);
    for (int i = 0; i < 6; i++) push_cmd(2'($urandom_range(0, 3)), 8'($urandom));
    drain("drain_burst");
    check("burst_saw_full", saw_full, 1);
    check("burst_pulses", pulse_times.size(), 7);
    check("burst_busy", busy, 0);
    check("burst_shadow", shadow_q, m_shadow);

    // Feedback disagreement after CLEAR FF
    push_cmd(OP_CLEAR, 8'hFF);
    drain("drain_mm");
    check("mm_shadow", shadow_q, 8'h00);
    q_fb = 8'h01;
`ifdef CT_SHADOW_CHECK_EN
    exp_mismatch = 1'b1;
`endif
    tick(); tick(); tick();
    check("mm_set", mismatch, exp_mismatch);
    q_fb = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    check("mm_sticky", mismatch, exp_mismatch);

    // Reset in the middle of a pulse with a command still queued
    push_cmd(OP_SET, 8'h81);
    push_cmd(OP_TOGGLE, 8'hFF);
    g = 0;
    while (!lat_clk && g < 50) begin
      tick();
      g++;
    end
    check("rst_wait_pulse", lat_clk, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_clk", lat_clk, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", cmd_ready, 1);
    check("rstmid_shadow", shadow_q, 8'h00);
    check("rstmid_c", lat_c, 8'hFF);
    check("rstmid_mismatch", mismatch, 0);
    model_q.delete();
    m_shadow     = '0;
    q_fb         = '0;
    exp_mismatch = 1'b0;
    tick(); tick();
    pulse_times.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_pulses", pulse_times.size(), 0);
    check("post_rst_busy", busy, 0);

    push_cmd(OP_SET, 8'h0F);
    drain("drain_post_rst");
    check("post_rst_shadow", shadow_q, 8'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", ncyc);
    $fatal(1, "timeout");
  end

endmodule
